tlp_replay_transmitter: RTL and testbench

Transmit-side Data Link Layer sequencing and replay control for PCIe TLPs. It assigns NEXT_TRANSMIT_SEQ to each TLP handed down from the Transaction Layer and records (seq, handle) in a circular retry store. It purges entries on Ack/Nak DLLPs from the link partner's receiver and replays unacknowledged TLPs on Nak or replay-timer expiry. REPLAY_NUM rollover requests link retrain. Payload storage lives outside the block; only handles are kept.

---
 rtl/pcie_dll_pkg.sv | 19 +
 rtl/tlp_retry_store.sv | 88 ++++++++
 rtl/tlp_replay_transmitter.sv | 171 +++++++++++++++++
 tb/tb_tlp_replay_transmitter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pcie_dll_pkg.sv
// Shared Data Link Layer types: sequence numbers, modulo distance and the
// transmit replay state encoding.
package pcie_dll_pkg;

  localparam int SEQ_NUM_WIDTH = 12;

  typedef logic [SEQ_NUM_WIDTH-1:0] seq_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REPLAY = 1'b1
  } state_e;

  // Forward distance from b to a, wrapping at 2^SEQ_NUM_WIDTH.
  function automatic seq_t seq_diff(input seq_t a, input seq_t b);
    return seq_t'(a - b);
  endfunction

endpackage

// File: rtl/tlp_retry_store.sv
// Circular store of {seq, handle} for unacknowledged TLPs. The replay cursor is
// kept as an offset from rd_ptr so purges simply pull it back toward zero.
module tlp_retry_store
  import pcie_dll_pkg::*;
#(
  parameter int HANDLE_WIDTH = 8,
  parameter int RETRY_DEPTH  = 16,
  localparam int PW = $clog2(RETRY_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    wr_en,
  input  seq_t                    wr_seq,
  input  logic [HANDLE_WIDTH-1:0] wr_handle,
  input  logic [CW-1:0]           adv_d,
  input  logic                    rp_load,
  input  logic                    rp_step,
  output logic [CW-1:0]           count,
  output logic [CW-1:0]           count_next,
  output logic                    rp_done,
  output logic                    rp_done_next,
  output seq_t                    rp_seq,
  output logic [HANDLE_WIDTH-1:0] rp_handle
);

  logic [PW-1:0]           wr_ptr_r;
  logic [PW-1:0]           rd_ptr_r;
  logic [CW-1:0]           count_r;
  logic [CW-1:0]           rp_off_r;
  logic [CW-1:0]           rp_base_s;
  logic [CW-1:0]           rp_off_next_s;
  logic [CW-1:0]           count_next_s;
  logic [PW-1:0]           rp_ptr_s;
  seq_t                    seq_mem_r [RETRY_DEPTH];
  logic [HANDLE_WIDTH-1:0] hdl_mem_r [RETRY_DEPTH];

  // Occupancy and replay-cursor arithmetic for the coming edge.
  always_comb begin
    count_next_s = count_r + {{PW{1'b0}}, wr_en} - adv_d;
    rp_base_s    = rp_off_r + {{PW{1'b0}}, rp_step};
    if (rp_load) begin
      rp_off_next_s = {CW{1'b0}};
    end else if (rp_base_s >= adv_d) begin
      rp_off_next_s = rp_base_s - adv_d;
    end else begin
      rp_off_next_s = {CW{1'b0}};
    end
  end

  // Pointer, count and cursor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      rp_off_r <= {CW{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      rp_off_r <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, wr_en};
      rd_ptr_r <= rd_ptr_r + adv_d[PW-1:0];
      count_r  <= count_next_s;
      rp_off_r <= rp_off_next_s;
    end
  end

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      seq_mem_r[wr_ptr_r] <= wr_seq;
      hdl_mem_r[wr_ptr_r] <= wr_handle;
    end
  end

  assign rp_ptr_s     = rd_ptr_r + rp_off_r[PW-1:0];
  assign rp_seq       = seq_mem_r[rp_ptr_s];
  assign rp_handle    = hdl_mem_r[rp_ptr_s];
  assign count        = count_r;
  assign count_next   = count_next_s;
  assign rp_done      = (rp_off_r == count_r);
  assign rp_done_next = (rp_off_next_s == count_next_s);

endmodule

// File: rtl/tlp_replay_transmitter.sv
// Transmit-side DLL sequencing: numbers outgoing TLPs, purges on Ack/Nak and
// replays outstanding TLPs on Nak or replay-timer expiry.
module tlp_replay_transmitter
  import pcie_dll_pkg::*;
#(
  parameter int                    HANDLE_WIDTH   = 8,
  parameter int                    RETRY_DEPTH    = 16,
  parameter int                    TIMER_WIDTH    = 16,
  parameter logic [TIMER_WIDTH-1:0] REPLAY_TIMEOUT = 16'h0100,
  localparam int CW = $clog2(RETRY_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dl_inactive,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [HANDLE_WIDTH-1:0] in_handle,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output seq_t                    tx_seq,
  output logic [HANDLE_WIDTH-1:0] tx_handle,
  output logic                    tx_is_replay,
  input  logic                    acknak_valid,
  input  logic                    acknak_is_nak,
  input  seq_t                    acknak_seq,
  output seq_t                    next_transmit_seq,
  output seq_t                    ackd_seq,
  output logic [CW-1:0]           retry_count,
  output logic [1:0]              replay_num,
  output logic [TIMER_WIDTH-1:0]  replay_timer,
  output logic                    replay_active,
  output logic                    retrain_req,
  output logic                    dllp_error
);

  state_e                  state_r, next_state_s;
  seq_t                    nts_r, ackd_r, d_s;
  logic [1:0]              replay_num_r, replay_num_next_s, num_base_s;
  logic [TIMER_WIDTH-1:0]  timer_r, timer_next_s;
  logic                    retrain_r, retrain_next_s, dllp_err_r;
  logic                    bad_seq_s, ack_ok_s, progress_s, full_s, accept_s;
  logic                    wr_en_s, rp_step_s, trigger_s;
  logic [CW-1:0]           adv_d_s, count_s, count_next_s;
  logic                    rp_done_s, rp_done_next_s;
  seq_t                    rp_seq_s;
  logic [HANDLE_WIDTH-1:0] rp_handle_s;

  tlp_retry_store #(
    .HANDLE_WIDTH(HANDLE_WIDTH),
    .RETRY_DEPTH (RETRY_DEPTH)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (dl_inactive),
    .wr_en       (wr_en_s),
    .wr_seq      (nts_r),
    .wr_handle   (in_handle),
    .adv_d       (adv_d_s),
    .rp_load     (trigger_s),
    .rp_step     (rp_step_s),
    .count       (count_s),
    .count_next  (count_next_s),
    .rp_done     (rp_done_s),
    .rp_done_next(rp_done_next_s),
    .rp_seq      (rp_seq_s),
    .rp_handle   (rp_handle_s)
  );

  // An out-of-range AckNak_Seq_Num is dropped and has no side effects.
  assign d_s        = seq_diff(acknak_seq, ackd_r);
  assign bad_seq_s  = acknak_valid & (d_s > seq_t'(count_s));
  assign ack_ok_s   = acknak_valid & ~bad_seq_s;
  assign adv_d_s    = ack_ok_s ? d_s[CW-1:0] : {CW{1'b0}};
  assign progress_s = ack_ok_s & (d_s != {SEQ_NUM_WIDTH{1'b0}});
  assign full_s     = (count_s == CW'(RETRY_DEPTH));
  assign accept_s   = tx_ready & ~full_s & ~dl_inactive;

  // Transmit mux, handshake and replay-cursor stepping.
  always_comb begin
    in_ready     = 1'b0;
    tx_valid     = 1'b0;
    tx_seq       = nts_r;
    tx_handle    = in_handle;
    tx_is_replay = 1'b0;
    wr_en_s      = 1'b0;
    rp_step_s    = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = accept_s;
        tx_valid = in_valid & ~full_s & ~dl_inactive;
        wr_en_s  = in_valid & accept_s;
      end
      REPLAY: begin
        tx_valid     = ~rp_done_s & ~dl_inactive;
        tx_seq       = rp_seq_s;
        tx_handle    = rp_handle_s;
        tx_is_replay = 1'b1;
        rp_step_s    = ~rp_done_s & ~dl_inactive & tx_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Replay trigger, next state, REPLAY_NUM and timer update.
  always_comb begin
    trigger_s = (state_r == IDLE) & (count_next_s != {CW{1'b0}}) &
                ((ack_ok_s & acknak_is_nak) | (timer_r == REPLAY_TIMEOUT));
    case (state_r)
      IDLE:    next_state_s = trigger_s ? REPLAY : IDLE;
      REPLAY:  next_state_s = rp_done_next_s ? IDLE : REPLAY;
      default: next_state_s = IDLE;
    endcase
    num_base_s     = progress_s ? 2'd0 : replay_num_r;
    retrain_next_s = 1'b0;
    if (trigger_s) begin
      replay_num_next_s = num_base_s + 2'd1;
      retrain_next_s    = (num_base_s == 2'd3);
    end else begin
      replay_num_next_s = num_base_s;
    end
    if ((count_next_s == {CW{1'b0}}) || progress_s || trigger_s) begin
      timer_next_s = {TIMER_WIDTH{1'b0}};
    end else if ((state_r == IDLE) && (count_s != {CW{1'b0}}) &&
                 (timer_r != {TIMER_WIDTH{1'b1}})) begin
      timer_next_s = timer_r + {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      timer_next_s = timer_r;
    end
  end

  // Link state registers; dl_inactive clears exactly like reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      nts_r        <= {SEQ_NUM_WIDTH{1'b0}};
      ackd_r       <= {SEQ_NUM_WIDTH{1'b1}};
      replay_num_r <= 2'd0;
      timer_r      <= {TIMER_WIDTH{1'b0}};
      retrain_r    <= 1'b0;
      dllp_err_r   <= 1'b0;
    end else if (dl_inactive) begin
      state_r      <= IDLE;
      nts_r        <= {SEQ_NUM_WIDTH{1'b0}};
      ackd_r       <= {SEQ_NUM_WIDTH{1'b1}};
      replay_num_r <= 2'd0;
      timer_r      <= {TIMER_WIDTH{1'b0}};
      retrain_r    <= 1'b0;
      dllp_err_r   <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      nts_r        <= nts_r + {{(SEQ_NUM_WIDTH-1){1'b0}}, wr_en_s};
      ackd_r       <= ack_ok_s ? acknak_seq : ackd_r;
      replay_num_r <= replay_num_next_s;
      timer_r      <= timer_next_s;
      retrain_r    <= retrain_next_s;
      dllp_err_r   <= bad_seq_s;
    end
  end

  assign next_transmit_seq = nts_r;
  assign ackd_seq          = ackd_r;
  assign retry_count       = count_s;
  assign replay_num        = replay_num_r;
  assign replay_timer      = timer_r;
  assign replay_active     = (state_r == REPLAY);
  assign retrain_req       = retrain_r;
  assign dllp_error        = dllp_err_r;

endmodule

// File: tb/tb_tlp_replay_transmitter.sv
// Directed self-checking bench for tlp_replay_transmitter.
module tb_tlp_replay_transmitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dl_inactive = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_handle = 8'h00;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [11:0] tx_seq;
  logic [7:0]  tx_handle;
  logic        tx_is_replay;
  logic        acknak_valid = 1'b0;
  logic        acknak_is_nak = 1'b0;
  logic [11:0] acknak_seq = 12'h000;
  logic [11:0] next_transmit_seq;
  logic [11:0] ackd_seq;
  logic [4:0]  retry_count;
  logic [1:0]  replay_num;
  logic [15:0] replay_timer;
  logic        replay_active;
  logic        retrain_req;
  logic        dllp_error;

  int n_tests = 0;
  int n_fail  = 0;

  tlp_replay_transmitter dut (
    .clk(clk), .rst_n(rst_n), .dl_inactive(dl_inactive),
    .in_valid(in_valid), .in_ready(in_ready), .in_handle(in_handle),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_seq(tx_seq),
    .tx_handle(tx_handle), .tx_is_replay(tx_is_replay),
    .acknak_valid(acknak_valid), .acknak_is_nak(acknak_is_nak), .acknak_seq(acknak_seq),
    .next_transmit_seq(next_transmit_seq), .ackd_seq(ackd_seq), .retry_count(retry_count),
    .replay_num(replay_num), .replay_timer(replay_timer), .replay_active(replay_active),
    .retrain_req(retrain_req), .dllp_error(dllp_error)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_link();
    dl_inactive = 1'b1;
    cyc();
    dl_inactive = 1'b0;
  endtask

  task automatic send(input logic [7:0] h);
    in_valid = 1'b1; in_handle = h; tx_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic acknak(input logic nak, input logic [11:0] s);
    acknak_valid = 1'b1; acknak_is_nak = nak; acknak_seq = s;
    cyc();
    acknak_valid = 1'b0; acknak_is_nak = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    n_tests++; if (next_transmit_seq !== 12'h000) begin n_fail++; $display("FAIL reset_nts got %0h want 0", next_transmit_seq); end
    n_tests++; if (ackd_seq !== 12'hFFF) begin n_fail++; $display("FAIL reset_ackd got %0h want fff", ackd_seq); end
    n_tests++; if ({retry_count, replay_num, replay_timer} !== 23'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d/%0h want 0/0/0", retry_count, replay_num, replay_timer); end
    n_tests++; if ({replay_active, retrain_req, dllp_error, tx_valid} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {replay_active, retrain_req, dllp_error, tx_valid}); end
  endtask

  task automatic test_send3();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_handle = 8'hA0 + 8'(k); tx_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({tx_valid, in_ready, tx_is_replay} !== 3'b110 || tx_seq !== 12'(k) || tx_handle !== 8'hA0 + 8'(k)) begin
        n_fail++; $display("FAIL send3_tx%0d got v=%b r=%b rp=%b seq=%0d h=%0h want 1 1 0 %0d %0h",
                           k, tx_valid, in_ready, tx_is_replay, tx_seq, tx_handle, k, 8'hA0 + 8'(k));
      end
      cyc();
    end
    in_valid = 1'b0;
    n_tests++; if (next_transmit_seq !== 12'd3) begin n_fail++; $display("FAIL send3_nts got %0d want 3", next_transmit_seq); end
    n_tests++; if (retry_count !== 5'd3) begin n_fail++; $display("FAIL send3_count got %0d want 3", retry_count); end
    n_tests++; if (ackd_seq !== 12'hFFF) begin n_fail++; $display("FAIL send3_ackd got %0h want fff", ackd_seq); end
  endtask

  task automatic test_ack();
    acknak(1'b0, 12'd1);
    n_tests++; if (retry_count !== 5'd1) begin n_fail++; $display("FAIL ack_count got %0d want 1", retry_count); end
    n_tests++; if (ackd_seq !== 12'd1) begin n_fail++; $display("FAIL ack_ackd got %0d want 1", ackd_seq); end
    n_tests++; if (replay_timer !== 16'd0 || replay_num !== 2'd0) begin n_fail++; $display("FAIL ack_clear got t=%0d n=%0d want 0 0", replay_timer, replay_num); end
  endtask

  task automatic test_nak_replay();
    clear_link();
    n_tests++; if (next_transmit_seq !== 12'd0 || retry_count !== 5'd0 || ackd_seq !== 12'hFFF) begin n_fail++; $display("FAIL dl_clear got nts=%0d c=%0d a=%0h want 0 0 fff", next_transmit_seq, retry_count, ackd_seq); end
    for (int k = 0; k < 3; k++) send(8'hB0 + 8'(k));
    acknak(1'b1, 12'd0);
    n_tests++; if (replay_active !== 1'b1 || retry_count !== 5'd2 || ackd_seq !== 12'd0 || replay_num !== 2'd1) begin
      n_fail++; $display("FAIL nak_enter got act=%b c=%0d a=%0d n=%0d want 1 2 0 1", replay_active, retry_count, ackd_seq, replay_num); end
    tx_ready = 1'b0; in_valid = 1'b1; in_handle = 8'hEE;
    @(negedge clk);
    n_tests++; if ({tx_valid, tx_is_replay, in_ready} !== 3'b110 || tx_seq !== 12'd1 || tx_handle !== 8'hB1) begin
      n_fail++; $display("FAIL nak_rp1 got v=%b rp=%b r=%b seq=%0d h=%0h want 1 1 0 1 b1", tx_valid, tx_is_replay, in_ready, tx_seq, tx_handle); end
    tx_ready = 1'b1;
    cyc();
    @(negedge clk);
    n_tests++; if ({tx_valid, tx_is_replay, in_ready} !== 3'b110 || tx_seq !== 12'd2 || tx_handle !== 8'hB2) begin
      n_fail++; $display("FAIL nak_rp2 got v=%b rp=%b r=%b seq=%0d h=%0h want 1 1 0 2 b2", tx_valid, tx_is_replay, in_ready, tx_seq, tx_handle); end
    cyc();
    in_valid = 1'b0;
    n_tests++; if (replay_active !== 1'b0 || replay_num !== 2'd1 || next_transmit_seq !== 12'd3 || retry_count !== 5'd2) begin
      n_fail++; $display("FAIL nak_exit got act=%b n=%0d nts=%0d c=%0d want 0 1 3 2", replay_active, replay_num, next_transmit_seq, retry_count); end
  endtask

  task automatic test_timeout_retrain();
    int n_rep = 0;
    logic prev_act = 1'b0;
    clear_link();
    send(8'h11);
    tx_ready = 1'b1;
    for (int c = 0; c < 3000 && n_rep < 4; c++) begin
      cyc();
      if (replay_active && !prev_act) begin
        n_rep++;
        n_tests++; if (retrain_req !== (n_rep == 4) || replay_num !== 2'(n_rep % 4)) begin
          n_fail++; $display("FAIL timeout_rep%0d got retrain=%b n=%0d want %b %0d", n_rep, retrain_req, replay_num, n_rep == 4, n_rep % 4); end
      end
      prev_act = replay_active;
    end
    n_tests++; if (n_rep !== 4) begin n_fail++; $display("FAIL timeout_count got %0d replays want 4", n_rep); end
    cyc();
    n_tests++; if (retrain_req !== 1'b0 || replay_num !== 2'd0) begin n_fail++; $display("FAIL timeout_pulse got retrain=%b n=%0d want 0 0", retrain_req, replay_num); end
  endtask

  task automatic test_dllp_error();
    clear_link();
    for (int k = 0; k < 3; k++) send(8'hC0 + 8'(k));
    acknak(1'b0, 12'd100);
    n_tests++; if (dllp_error !== 1'b1) begin n_fail++; $display("FAIL dllp_err_pulse got %b want 1", dllp_error); end
    n_tests++; if (retry_count !== 5'd3 || ackd_seq !== 12'hFFF || replay_active !== 1'b0) begin
      n_fail++; $display("FAIL dllp_err_state got c=%0d a=%0h act=%b want 3 fff 0", retry_count, ackd_seq, replay_active); end
    cyc();
    n_tests++; if (dllp_error !== 1'b0) begin n_fail++; $display("FAIL dllp_err_clear got %b want 0", dllp_error); end
  endtask

  task automatic test_wrap_fill_clear();
    int bad = 0;
    clear_link();
    for (int i = 0; i < 4100; i++) begin
      in_valid = 1'b1; in_handle = i[7:0]; tx_ready = 1'b1;
      @(negedge clk);
      if (tx_seq !== i[11:0] || in_ready !== 1'b1) bad++;
      if (i == 4096) begin
        n_tests++; if (tx_seq !== 12'd0) begin n_fail++; $display("FAIL wrap_seq got %0d want 0", tx_seq); end
      end
      cyc();
      in_valid = 1'b0;
      if ((i % 8) == 7) acknak(1'b0, i[11:0]);
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL wrap_stream got %0d bad handshakes want 0", bad); end
    n_tests++; if (next_transmit_seq !== 12'd4 || retry_count !== 5'd4 || ackd_seq !== 12'hFFF) begin
      n_fail++; $display("FAIL wrap_state got nts=%0d c=%0d a=%0h want 4 4 fff", next_transmit_seq, retry_count, ackd_seq); end
    for (int j = 0; j < 12; j++) send(8'h55);
    in_valid = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b0 || tx_valid !== 1'b0 || retry_count !== 5'd16) begin
      n_fail++; $display("FAIL full got r=%b v=%b c=%0d want 0 0 16", in_ready, tx_valid, retry_count); end
    in_valid = 1'b0; tx_ready = 1'b0;
    acknak(1'b1, 12'hFFF);
    @(negedge clk);
    n_tests++; if (replay_active !== 1'b1 || tx_is_replay !== 1'b1 || tx_seq !== 12'd0 || tx_handle !== 8'h00) begin
      n_fail++; $display("FAIL full_replay got act=%b rp=%b seq=%0d h=%0h want 1 1 0 0", replay_active, tx_is_replay, tx_seq, tx_handle); end
    cyc();
    clear_link();
    @(negedge clk);
    n_tests++; if ({replay_active, tx_valid, retrain_req, dllp_error} !== 4'b0000 || next_transmit_seq !== 12'd0 ||
                   ackd_seq !== 12'hFFF || retry_count !== 5'd0 || replay_timer !== 16'd0 || replay_num !== 2'd0) begin
      n_fail++; $display("FAIL mid_replay_clear got act=%b v=%b nts=%0d a=%0h c=%0d t=%0d n=%0d want 0 0 0 fff 0 0 0",
                         replay_active, tx_valid, next_transmit_seq, ackd_seq, retry_count, replay_timer, replay_num); end
  endtask

  initial begin
    test_reset();
    test_send3();
    test_ack();
    test_nak_replay();
    test_timeout_retrain();
    test_dllp_error();
    test_wrap_fill_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
